buffer_xfer_ctrl: RTL and testbench

- Parametrised transfer/stall controller for the custom-0 buffer instructions: LBUF (dmem -> buffer), SBUF (buffer -> dmem) and SHA3 write-back wait.
- Sequences a configurable number of word beats with a per-beat memory handshake, drives the shared dmem/buffer offset and per-channel buffer strobes, and holds the pipeline stall until the transfer completes.
- Sits between the decode stage and the buffer / dmem / SHA3 datapath.

---
 rtl/buffer_xfer_ctrl.sv | 155 +++++++++++++++
 tb/tb_buffer_xfer_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : buffer_xfer_ctrl
// Purpose  : Beat sequencer and pipeline-stall controller for LBUF/SBUF/SHA3 wait
// Revision : 1.0 - initial release
// ============================================================================
module buffer_xfer_ctrl #(
    parameter int ADDR_BITS = 5,
    parameter int DEPTH     = 25,
    parameter int NUM_CH    = 2,
    parameter int CH_BITS   = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [CH_BITS-1:0]   chan_i,
    input  logic [ADDR_BITS:0]   amount_i,
    input  logic                 sha3_busy_i,
    input  logic                 mem_ready_i,
    output logic                 stall_o,
    output logic                 busy_o,
    output logic [ADDR_BITS-1:0] offset_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic [NUM_CH-1:0]    buf_we_o,
    output logic [NUM_CH-1:0]    buf_re_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [ADDR_BITS:0] c_depth  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [CH_BITS:0]   c_num_ch = (CH_BITS+1)'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SWAIT = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q,   cnt_d;
    logic [ADDR_BITS:0]   len_q,   len_d;
    logic [CH_BITS-1:0]   chan_q,  chan_d;
    logic                 err_q,   err_d;

    logic                 w_legal;
    logic [ADDR_BITS:0]   w_len;
    logic                 w_last;
    logic [NUM_CH-1:0]    w_chan_oh;

    // A request is legal only for LBUF/SBUF on an existing channel.
    assign w_legal   = ~mode_i[1] && ({1'b0, chan_i} < c_num_ch);
    assign w_len     = (amount_i > c_depth) ? c_depth : amount_i;
    assign w_last    = (({1'b0, cnt_q} + (ADDR_BITS+1)'(1)) == len_q);
    assign w_chan_oh = NUM_CH'(1) << chan_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            chan_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        chan_d   = chan_q;
        err_d    = 1'b0;
        stall_o  = 1'b0;
        busy_o   = 1'b0;
        offset_o = '0;
        mem_re_o = 1'b0;
        mem_we_o = 1'b0;
        buf_we_o = '0;
        buf_re_o = '0;
        done_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (w_legal) begin
                        // Stall the requesting instruction in its own issue cycle.
                        stall_o = 1'b1;
                        chan_d  = chan_i;
                        len_d   = w_len;
                        cnt_d   = '0;
                        if (w_len == '0)
                            state_d = S_DONE;
                        else if (mode_i[0])
                            state_d = S_SWAIT;
                        else
                            state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SWAIT: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                if (!sha3_busy_i)
                    state_d = S_STORE;
            end

            S_LOAD, S_STORE: begin
                stall_o  = 1'b1;
                busy_o   = 1'b1;
                offset_o = cnt_q;
                if (state_q == S_LOAD) begin
                    mem_re_o = 1'b1;
                    buf_we_o = w_chan_oh;
                end else begin
                    mem_we_o = 1'b1;
                    buf_re_o = w_chan_oh;
                end
                // Counter advances only on an accepted beat and never wraps.
                if (mem_ready_i) begin
                    if (w_last)
                        state_d = S_DONE;
                    else
                        cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end

            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_buffer_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_xfer_ctrl
// Purpose  : Directed self-checking bench with a cycle-trace model of transfers
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_xfer_ctrl;

    logic       CLK;
    logic       RST;
    logic       start_i;
    logic [1:0] mode_i;
    logic [1:0] chan_i;
    logic [5:0] amount_i;
    logic       sha3_busy_i;
    logic       mem_ready_i;
    logic       stall_o;
    logic       busy_o;
    logic [4:0] offset_o;
    logic       mem_re_o;
    logic       mem_we_o;
    logic [1:0] buf_we_o;
    logic [1:0] buf_re_o;
    logic       done_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    buffer_xfer_ctrl #(
        .ADDR_BITS(5),
        .DEPTH    (25),
        .NUM_CH   (2),
        .CH_BITS  (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .chan_i     (chan_i),
        .amount_i   (amount_i),
        .sha3_busy_i(sha3_busy_i),
        .mem_ready_i(mem_ready_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .offset_o   (offset_o),
        .mem_re_o   (mem_re_o),
        .mem_we_o   (mem_we_o),
        .buf_we_o   (buf_we_o),
        .buf_re_o   (buf_re_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One cycle of the expected trace: inputs to drive and outputs required.
    typedef struct {
        logic       start;
        logic [1:0] mode;
        logic [1:0] chan;
        logic [5:0] amount;
        logic       sbusy;
        logic       rdy;
        logic       e_stall;
        logic       e_busy;
        logic [4:0] e_off;
        logic       e_mre;
        logic       e_mwe;
        logic [1:0] e_bwe;
        logic [1:0] e_bre;
        logic       e_done;
        logic       e_err;
    } cyc_t;

    cyc_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c = '{default: '0};
        return c;
    endfunction

    // Expected trace of one request: start cycle, optional SHA3 wait, beats, done.
    task automatic build_xfer(input logic [1:0] mode, input logic [1:0] chan, input int amount,
                              input int sbusy_cycles, input int wait_beat, input int wait_len);
        cyc_t c;
        int   len;
        int   nw;
        c        = idle_cyc();
        c.start  = 1'b1;
        c.mode   = mode;
        c.chan   = chan;
        c.amount = 6'(amount);
        if (mode[1] || chan >= 2'd2) begin
            q.push_back(c);
            c = idle_cyc();
            c.e_err = 1'b1;
            q.push_back(c);
            q.push_back(idle_cyc());
            return;
        end
        len = (amount > 25) ? 25 : amount;
        c.e_stall = 1'b1;
        q.push_back(c);
        if (len > 0 && mode == 2'b01) begin
            for (int i = 0; i <= sbusy_cycles; i++) begin
                c = idle_cyc();
                c.sbusy   = (i < sbusy_cycles);
                c.e_stall = 1'b1;
                c.e_busy  = 1'b1;
                q.push_back(c);
            end
        end
        for (int k = 0; k < len; k++) begin
            nw = (k == wait_beat) ? wait_len : 0;
            for (int j = 0; j <= nw; j++) begin
                c = idle_cyc();
                c.rdy     = (j == nw);
                c.e_stall = 1'b1;
                c.e_busy  = 1'b1;
                c.e_off   = 5'(k);
                if (mode == 2'b00) begin
                    c.e_mre = 1'b1;
                    c.e_bwe = 2'(1) << chan;
                end else begin
                    c.e_mwe = 1'b1;
                    c.e_bre = 2'(1) << chan;
                end
                q.push_back(c);
            end
        end
        c = idle_cyc();
        c.e_busy = 1'b1;
        c.e_done = 1'b1;
        q.push_back(c);
        q.push_back(idle_cyc());
    endtask

    function automatic int model_done_idx();
        for (int i = 0; i < q.size(); i++)
            if (q[i].e_done) return i;
        return -1;
    endfunction

    task automatic run_queue(input string tag, output int done_at, output int beats,
                             output int errs, output int last_off);
        done_at  = -1;
        beats    = 0;
        errs     = 0;
        last_off = -1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            start_i     = q[i].start;
            mode_i      = q[i].mode;
            chan_i      = q[i].chan;
            amount_i    = q[i].amount;
            sha3_busy_i = q[i].sbusy;
            mem_ready_i = q[i].rdy;
            #2;
            chk($sformatf("%s[%0d].stall", tag, i), 32'(stall_o),  32'(q[i].e_stall));
            chk($sformatf("%s[%0d].busy",  tag, i), 32'(busy_o),   32'(q[i].e_busy));
            chk($sformatf("%s[%0d].off",   tag, i), 32'(offset_o), 32'(q[i].e_off));
            chk($sformatf("%s[%0d].mre",   tag, i), 32'(mem_re_o), 32'(q[i].e_mre));
            chk($sformatf("%s[%0d].mwe",   tag, i), 32'(mem_we_o), 32'(q[i].e_mwe));
            chk($sformatf("%s[%0d].bwe",   tag, i), 32'(buf_we_o), 32'(q[i].e_bwe));
            chk($sformatf("%s[%0d].bre",   tag, i), 32'(buf_re_o), 32'(q[i].e_bre));
            chk($sformatf("%s[%0d].done",  tag, i), 32'(done_o),   32'(q[i].e_done));
            chk($sformatf("%s[%0d].err",   tag, i), 32'(err_o),    32'(q[i].e_err));
            if (done_o && done_at < 0) done_at = i;
            if ((mem_re_o || mem_we_o) && mem_ready_i) begin
                beats++;
                last_off = int'(offset_o);
            end
            if (err_o) errs++;
        end
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"}, 32'(stall_o),  32'd0);
        chk({tag, ".busy"},  32'(busy_o),   32'd0);
        chk({tag, ".off"},   32'(offset_o), 32'd0);
        chk({tag, ".mre"},   32'(mem_re_o), 32'd0);
        chk({tag, ".mwe"},   32'(mem_we_o), 32'd0);
        chk({tag, ".bwe"},   32'(buf_we_o), 32'd0);
        chk({tag, ".bre"},   32'(buf_re_o), 32'd0);
        chk({tag, ".done"},  32'(done_o),   32'd0);
        chk({tag, ".err"},   32'(err_o),    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, b, e, lo;
        RST = 1'b1; start_i = 1'b0; mode_i = 2'b00; chan_i = 2'd0; amount_i = 6'd0;
        sha3_busy_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;

        // LBUF chan 1, 25 words, memory always ready.
        build_xfer(2'b00, 2'd1, 25, 0, -1, 0);
        chk("pin.lbuf25.done_idx", 32'(model_done_idx()), 32'd26);
        run_queue("lbuf25", d, b, e, lo);
        chk("lbuf25.done_at", 32'(d), 32'd26);
        chk("lbuf25.beats", 32'(b), 32'd25);
        chk("lbuf25.last_off", 32'(lo), 32'd24);

        // SBUF chan 0 with SHA3 busy for 3 cycles after start.
        build_xfer(2'b01, 2'd0, 25, 3, -1, 0);
        chk("pin.sbuf.done_idx", 32'(model_done_idx()), 32'd30);
        run_queue("sbuf", d, b, e, lo);
        chk("sbuf.done_at", 32'(d), 32'd30);
        chk("sbuf.beats", 32'(b), 32'd25);

        // LBUF 4 words, mem_ready low for 2 cycles on beat 2.
        build_xfer(2'b00, 2'd0, 4, 0, 2, 2);
        chk("pin.lbuf4w.done_idx", 32'(model_done_idx()), 32'd7);
        run_queue("lbuf4w", d, b, e, lo);
        chk("lbuf4w.done_at", 32'(d), 32'd7);
        chk("lbuf4w.beats", 32'(b), 32'd4);

        // Zero-length request completes immediately.
        build_xfer(2'b00, 2'd1, 0, 0, -1, 0);
        run_queue("len0", d, b, e, lo);
        chk("len0.done_at", 32'(d), 32'd1);
        chk("len0.beats", 32'(b), 32'd0);

        // Oversized request is clamped to DEPTH.
        build_xfer(2'b01, 2'd1, 40, 0, -1, 0);
        run_queue("amt40", d, b, e, lo);
        chk("amt40.beats", 32'(b), 32'd25);
        chk("amt40.last_off", 32'(lo), 32'd24);
        chk("amt40.done_at", 32'(d), 32'd27);

        // Illegal mode and illegal channel.
        build_xfer(2'b10, 2'd0, 5, 0, -1, 0);
        run_queue("mode10", d, b, e, lo);
        chk("mode10.errs", 32'(e), 32'd1);
        chk("mode10.beats", 32'(b), 32'd0);
        build_xfer(2'b00, 2'd2, 5, 0, -1, 0);
        run_queue("chan2", d, b, e, lo);
        chk("chan2.errs", 32'(e), 32'd1);
        chk("chan2.done_at", 32'(d), 32'hFFFF_FFFF);

        // A second start issued mid-transfer must be ignored.
        build_xfer(2'b00, 2'd0, 6, 0, -1, 0);
        q[3].start = 1'b1; q[3].mode = 2'b01; q[3].chan = 2'd1; q[3].amount = 6'd3;
        q[5].start = 1'b1; q[5].mode = 2'b11; q[5].chan = 2'd3; q[5].amount = 6'd1;
        run_queue("midstart", d, b, e, lo);
        chk("midstart.beats", 32'(b), 32'd6);
        chk("midstart.errs", 32'(e), 32'd0);
        chk("midstart.done_at", 32'(d), 32'd7);

        // Reset while LOAD sits at offset 10.
        build_xfer(2'b00, 2'd1, 25, 0, -1, 0);
        while (q.size() > 12) void'(q.pop_back());
        run_queue("prerst", d, b, e, lo);
        chk("prerst.last_off", 32'(lo), 32'd10);
        RST = 1'b1;
        mem_ready_i = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (2) begin
            @(negedge CLK);
            #1;
            check_all_zero("rst_hold");
        end
        RST = 1'b0;
        @(negedge CLK);
        #1;
        check_all_zero("rst_after");

        build_xfer(2'b00, 2'd1, 3, 0, -1, 0);
        run_queue("postrst", d, b, e, lo);
        chk("postrst.beats", 32'(b), 32'd3);
        chk("postrst.done_at", 32'(d), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
